// File: rtl/top_memory_access.sv
// rtl/top_memory_access.sv - memory stage: load/store bus sequencer with writeback latch
// IDLE issues one aligned access per memop and waits in BUSY for dmem_ack; illegal/misaligned ops flag mem_err.
module top_memory_access #(
    parameter int XLEN         = 32,
    parameter int OPLEN        = 16,
    parameter int OP_LOAD_BIT  = 0,
    parameter int OP_STORE_BIT = 1,
    parameter int F3_LSB       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phase_memory,
    input  logic [OPLEN-1:0] decoded_op_em,
    input  logic [XLEN-1:0]  rs2data_em,
    input  logic             jump_state_em,
    input  logic [4:0]       rdsel_em,
    input  logic [XLEN-1:0]  next_pc_em,
    input  logic [XLEN-1:0]  alu_out_em,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_ack,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [OPLEN-1:0] decoded_op_mw,
    output logic [XLEN-1:0]  rddata_mw,
    output logic [4:0]       rdsel_mw,
    output logic             jump_state_mw,
    output logic [XLEN-1:0]  next_pc_mw,
    output logic             stall_memory,
    output logic             mem_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  addr_q, addr_d, wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [1:0]       ea_lo_q, ea_lo_d;
    logic [2:0]       f3_q, f3_d;
    logic             mem_err_q, mem_err_d;
    logic [OPLEN-1:0] op_mw_q, op_mw_d;
    logic [XLEN-1:0]  rddata_mw_q, rddata_mw_d, next_pc_mw_q, next_pc_mw_d;
    logic [4:0]       rdsel_mw_q, rdsel_mw_d;
    logic             jump_mw_q, jump_mw_d;

    logic            is_load, is_store, memop, legal_f3, misaligned, stall_c, cap;
    logic [2:0]      f3;
    logic [XLEN-1:0] cap_rd, st_data, ld_data;
    logic [3:0]      st_be;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    always_comb begin
        is_load  = decoded_op_em[OP_LOAD_BIT];
        is_store = decoded_op_em[OP_STORE_BIT] & ~is_load;
        memop    = decoded_op_em[OP_LOAD_BIT] | decoded_op_em[OP_STORE_BIT];
        f3       = decoded_op_em[F3_LSB+2:F3_LSB];
        legal_f3 = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = is_load;
            default:                legal_f3 = 1'b0;
        endcase
        misaligned = ((f3[1:0] == 2'b01) && alu_out_em[0]) ||
                     ((f3[1:0] == 2'b10) && (alu_out_em[1:0] != 2'b00));
        case (f3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << alu_out_em[1:0];
                st_data = {(XLEN/8){rs2data_em[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << alu_out_em[1:0];
                st_data = {(XLEN/16){rs2data_em[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = rs2data_em;
            end
        endcase
    end

    // Load extraction uses the lane/width registered at issue, not the live inputs.
    always_comb begin
        ld_byte = dmem_rdata[{ea_lo_q, 3'b000} +: 8];
        ld_half = dmem_rdata[{ea_lo_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        be_d         = be_q;
        ea_lo_d      = ea_lo_q;
        f3_d         = f3_q;
        mem_err_d    = 1'b0;
        op_mw_d      = op_mw_q;
        rddata_mw_d  = rddata_mw_q;
        rdsel_mw_d   = rdsel_mw_q;
        jump_mw_d    = jump_mw_q;
        next_pc_mw_d = next_pc_mw_q;
        stall_c      = 1'b0;
        cap          = 1'b0;
        cap_rd       = '0;
        case (state_q)
            IDLE: begin
                if (phase_memory) begin
                    if (!memop) begin
                        cap    = 1'b1;
                        cap_rd = alu_out_em;
                    end else if (legal_f3 && !misaligned) begin
                        stall_c = 1'b1;
                        addr_d  = {alu_out_em[XLEN-1:2], 2'b00};
                        we_d    = is_store;
                        be_d    = is_store ? st_be : 4'b0000;
                        wdata_d = is_store ? st_data : '0;
                        ea_lo_d = alu_out_em[1:0];
                        f3_d    = f3;
                        state_d = BUSY;
                    end else begin
                        mem_err_d = 1'b1;
                        cap       = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall_c = ~dmem_ack;
                if (dmem_ack) begin
                    cap     = 1'b1;
                    cap_rd  = we_q ? alu_out_em : ld_data;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cap) begin
            op_mw_d      = decoded_op_em;
            rddata_mw_d  = cap_rd;
            rdsel_mw_d   = rdsel_em;
            jump_mw_d    = jump_state_em;
            next_pc_mw_d = next_pc_em;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            ea_lo_q      <= 2'b00;
            f3_q         <= 3'b000;
            mem_err_q    <= 1'b0;
            op_mw_q      <= '0;
            rddata_mw_q  <= '0;
            rdsel_mw_q   <= 5'd0;
            jump_mw_q    <= 1'b0;
            next_pc_mw_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            be_q         <= be_d;
            ea_lo_q      <= ea_lo_d;
            f3_q         <= f3_d;
            mem_err_q    <= mem_err_d;
            op_mw_q      <= op_mw_d;
            rddata_mw_q  <= rddata_mw_d;
            rdsel_mw_q   <= rdsel_mw_d;
            jump_mw_q    <= jump_mw_d;
            next_pc_mw_q <= next_pc_mw_d;
        end
    end

    assign dmem_req      = (state_q == BUSY);
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign stall_memory  = stall_c & ~rst;
    assign mem_err       = mem_err_q;
    assign decoded_op_mw = op_mw_q;
    assign rddata_mw     = rddata_mw_q;
    assign rdsel_mw      = rdsel_mw_q;
    assign jump_state_mw = jump_mw_q;
    assign next_pc_mw    = next_pc_mw_q;

endmodule

// File: tb/tb_top_memory_access.sv
// tb/tb_top_memory_access.sv - directed self-checking bench for top_memory_access
module tb_top_memory_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phase_memory = 1'b0;
    logic [15:0] decoded_op_em = '0;
    logic [31:0] rs2data_em = '0;
    logic        jump_state_em = 1'b0;
    logic [4:0]  rdsel_em = '0;
    logic [31:0] next_pc_em = '0;
    logic [31:0] alu_out_em = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [15:0] decoded_op_mw;
    logic [31:0] rddata_mw, next_pc_mw;
    logic [4:0]  rdsel_mw;
    logic        jump_state_mw, stall_memory, mem_err;

    int n_tests = 0;
    int n_fail  = 0;

    top_memory_access dut (
        .clk(clk), .rst(rst), .phase_memory(phase_memory),
        .decoded_op_em(decoded_op_em), .rs2data_em(rs2data_em),
        .jump_state_em(jump_state_em), .rdsel_em(rdsel_em),
        .next_pc_em(next_pc_em), .alu_out_em(alu_out_em),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .decoded_op_mw(decoded_op_mw),
        .rddata_mw(rddata_mw), .rdsel_mw(rdsel_mw),
        .jump_state_mw(jump_state_mw), .next_pc_mw(next_pc_mw),
        .stall_memory(stall_memory), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk_op(input logic ld, input logic st, input logic [2:0] f3);
        logic [15:0] op;
        op      = '0;
        op[0]   = ld;
        op[1]   = st;
        op[4:2] = f3;
        return op;
    endfunction

    // One legal access: phase cycle, `waits` cycles without ack, then the ack cycle.
    task automatic mem_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] ea, input logic [31:0] rs2, input logic [31:0] rdata,
                          input int waits, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
        int stalls;
        @(negedge clk);
        phase_memory  = 1'b1;
        decoded_op_em = mk_op(~st, st, f3);
        alu_out_em    = ea;
        rs2data_em    = rs2;
        rdsel_em      = 5'd9;
        dmem_rdata    = rdata;
        dmem_ack      = 1'b0;
        #1;
        check({tag, " issue stall"}, {31'b0, stall_memory}, 32'd1);
        check({tag, " issue noreq"}, {31'b0, dmem_req}, 32'd0);
        stalls = 1;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            if (i == 0) begin
                alu_out_em = 32'hDEAD_BEEF;
                rs2data_em = 32'h5555_AAAA;
                #1;
            end
            check({tag, " wait req"}, {31'b0, dmem_req}, 32'd1);
            check({tag, " wait addr"}, dmem_addr, exp_addr);
            check({tag, " wait be"}, {28'b0, dmem_be}, {28'b0, exp_be});
            check({tag, " wait wdata"}, dmem_wdata, exp_wdata);
            if (stall_memory) stalls++;
            alu_out_em = ea;
            rs2data_em = rs2;
        end
        @(negedge clk);
        check({tag, " req"}, {31'b0, dmem_req}, 32'd1);
        check({tag, " addr"}, dmem_addr, exp_addr);
        check({tag, " we"}, {31'b0, dmem_we}, {31'b0, st});
        check({tag, " be"}, {28'b0, dmem_be}, {28'b0, exp_be});
        check({tag, " wdata"}, dmem_wdata, exp_wdata);
        dmem_ack = 1'b1;
        #1;
        check({tag, " ack stall"}, {31'b0, stall_memory}, 32'd0);
        @(negedge clk);
        check({tag, " rddata"}, rddata_mw, exp_rd);
        check({tag, " rdsel"}, {27'b0, rdsel_mw}, 32'd9);
        check({tag, " req done"}, {31'b0, dmem_req}, 32'd0);
        check({tag, " stall count"}, stalls, waits + 1);
        phase_memory = 1'b0;
        dmem_ack     = 1'b0;
    endtask

    initial begin
        #1;
        check("reset req", {31'b0, dmem_req}, 32'd0);
        check("reset stall", {31'b0, stall_memory}, 32'd0);
        check("reset rddata", rddata_mw, 32'd0);
        check("reset mem_err", {31'b0, mem_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ALU pass-through
        @(negedge clk);
        phase_memory = 1'b1; decoded_op_em = 16'h0000; alu_out_em = 32'h1234;
        rdsel_em = 5'd5; next_pc_em = 32'h44; jump_state_em = 1'b1;
        #1;
        check("alu stall", {31'b0, stall_memory}, 32'd0);
        @(negedge clk);
        check("alu stall2", {31'b0, stall_memory}, 32'd0);
        check("alu rddata", rddata_mw, 32'h1234);
        check("alu rdsel", {27'b0, rdsel_mw}, 32'd5);
        check("alu next_pc", next_pc_mw, 32'h44);
        check("alu jump", {31'b0, jump_state_mw}, 32'd1);
        phase_memory = 1'b0; alu_out_em = 32'h9999; jump_state_em = 1'b0;
        @(negedge clk);
        check("hold rddata", rddata_mw, 32'h1234);

        mem_op("LB",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80);
        mem_op("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 32'h100, 4'b0000, 32'h0, 32'h0000_0080);
        mem_op("LH",  1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 1, 32'h100, 4'b0000, 32'h0, 32'hFFFF_8001);
        mem_op("LHU", 1'b0, 3'b101, 32'h100, 32'h0, 32'h8001_F00F, 0, 32'h100, 4'b0000, 32'h0, 32'h0000_F00F);
        mem_op("LW",  1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFE_F00D, 2, 32'h104, 4'b0000, 32'h0, 32'hCAFE_F00D);
        mem_op("SH",  1'b1, 3'b001, 32'h202, 32'hABCD_1234, 32'h0, 3, 32'h200, 4'b1100, 32'h1234_1234, 32'h202);
        mem_op("SB",  1'b1, 3'b000, 32'h301, 32'hABCD_12EF, 32'h0, 0, 32'h300, 4'b0010, 32'hEFEF_EFEF, 32'h301);
        mem_op("SW",  1'b1, 3'b010, 32'h40C, 32'h1357_9BDF, 32'h0, 1, 32'h40C, 4'b1111, 32'h1357_9BDF, 32'h40C);

        // Reset while BUSY, ack held through release
        @(negedge clk);
        phase_memory = 1'b1; decoded_op_em = mk_op(1'b1, 1'b0, 3'b010);
        alu_out_em = 32'h300; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        check("rstbusy req", {31'b0, dmem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstbusy req drop", {31'b0, dmem_req}, 32'd0);
        check("rstbusy stall", {31'b0, stall_memory}, 32'd0);
        check("rstbusy rddata", rddata_mw, 32'd0);
        check("rstbusy rdsel", {27'b0, rdsel_mw}, 32'd0);
        check("rstbusy be", {28'b0, dmem_be}, 32'd0);
        dmem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0; phase_memory = 1'b0;
        @(negedge clk);
        check("rstrel req", {31'b0, dmem_req}, 32'd0);
        check("rstrel rddata", rddata_mw, 32'd0);
        check("rstrel stall", {31'b0, stall_memory}, 32'd0);
        dmem_ack = 1'b0;

        // Misaligned LW, then illegal f3=011 load
        @(negedge clk);
        phase_memory = 1'b1; decoded_op_em = mk_op(1'b1, 1'b0, 3'b010);
        alu_out_em = 32'h101; rdsel_em = 5'd3;
        #1;
        check("misal stall", {31'b0, stall_memory}, 32'd0);
        @(negedge clk);
        check("misal err", {31'b0, mem_err}, 32'd1);
        check("misal req", {31'b0, dmem_req}, 32'd0);
        check("misal rddata", rddata_mw, 32'd0);
        check("misal rdsel", {27'b0, rdsel_mw}, 32'd3);
        phase_memory = 1'b0;
        @(negedge clk);
        check("misal err pulse", {31'b0, mem_err}, 32'd0);
        phase_memory = 1'b1; decoded_op_em = mk_op(1'b1, 1'b0, 3'b011);
        alu_out_em = 32'h100; rdsel_em = 5'd4;
        @(negedge clk);
        check("f3_011 err", {31'b0, mem_err}, 32'd1);
        check("f3_011 req", {31'b0, dmem_req}, 32'd0);
        check("f3_011 rdsel", {27'b0, rdsel_mw}, 32'd4);
        phase_memory = 1'b0;
        @(negedge clk);
        check("f3_011 err pulse", {31'b0, mem_err}, 32'd0);

        // Spurious ack in IDLE
        phase_memory = 1'b1; decoded_op_em = 16'h0000; alu_out_em = 32'h55;
        @(negedge clk);
        phase_memory = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        check("spur stall", {31'b0, stall_memory}, 32'd0);
        @(negedge clk);
        check("spur rddata", rddata_mw, 32'h55);
        check("spur req", {31'b0, dmem_req}, 32'd0);
        dmem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/top_memory_access.md
TOP_MEMORY_ACCESS -- requirements
Module: top_memory_access

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width.
REQ-002 SHALL have parameter OPLEN, default 16: decoded opcode width, matching the execute stage.
REQ-003 SHALL have parameter OP_LOAD_BIT, default 0: decoded_op bit marking a load.
REQ-004 SHALL have parameter OP_STORE_BIT, default 1: decoded_op bit marking a store.
REQ-005 SHALL have parameter F3_LSB, default 2: LSB of the 3-bit funct3 field in decoded_op.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk input 1, global clock; rst input 1, global reset.
REQ-007 SHALL have these execute-side inputs:
- phase_memory, 1: memory phase active.
- decoded_op_em, OPLEN: decoded opcode.
- rs2data_em, XLEN: store data.
- jump_state_em, 1: jump flag.
- rdsel_em, 5: destination register.
- next_pc_em, XLEN: next PC.
- alu_out_em, XLEN: ALU result and effective address.
REQ-008 SHALL have these data-bus ports:
- dmem_req, out 1.
- dmem_we, out 1.
- dmem_addr, out XLEN: word aligned, [1:0]=0.
- dmem_be, out 4.
- dmem_wdata, out XLEN.
- dmem_ack, in 1.
- dmem_rdata, in XLEN.
REQ-009 SHALL have these writeback-side outputs:
- decoded_op_mw, OPLEN.
- rddata_mw, XLEN.
- rdsel_mw, 5.
- jump_state_mw, 1.
- next_pc_mw, XLEN.
REQ-010 SHALL have these state-machine outputs:
- stall_memory, out 1.
- mem_err, out 1: one-cycle error pulse.

Function
REQ-011 SHALL implement FSM states IDLE and BUSY, with reset state IDLE.
REQ-012 Memop SHALL mean decoded_op_em[OP_LOAD_BIT] | decoded_op_em[OP_STORE_BIT], with f3 = decoded_op_em[F3_LSB+2:F3_LSB] and ea = alu_out_em.
REQ-013 A legal load SHALL have f3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}; a legal store SHALL have f3 in {000 SB, 001 SH, 010 SW}.
REQ-014 An access SHALL be misaligned when a halfword has ea[0]=1 or a word has ea[1:0]!=0.
REQ-015 In IDLE with phase_memory=1 and no memop, the output latch SHALL capture all _em fields with rddata_mw=alu_out_em on that edge, with stall_memory=0 (1-cycle stage).
REQ-016 In IDLE with phase_memory=1 and a legal, aligned memop:
- stall_memory=1 combinationally.
- On the edge: register addr={ea[XLEN-1:2],2'b00}, we, be, wdata, ea[1:0], f3; go to BUSY.
REQ-017 In IDLE with phase_memory=1 and an illegal f3 or a misaligned memop:
- No bus request.
- mem_err=1 for the next cycle only.
- Latch captures the _em fields with rddata_mw=0.
- stall_memory=0.
REQ-018 In BUSY, dmem_req SHALL be 1 with addr/we/be/wdata held stable until dmem_ack.
REQ-019 In BUSY, stall_memory SHALL equal !dmem_ack.
REQ-020 On the BUSY cycle with dmem_ack=1, the latch SHALL capture the _em fields plus load data (store: rddata_mw=alu_out_em), and the FSM SHALL return to IDLE.
REQ-021 dmem_ack while not in BUSY SHALL be ignored.
REQ-022 Minimum memop latency SHALL be 2 cycles (phase cycle + ack cycle); each wait cycle adds 1.
REQ-023 Byte enables SHALL be:
- SB: 4'b0001<<ea[1:0].
- SH: 4'b0011<<ea[1:0].
- SW: 4'b1111.
REQ-024 Store data SHALL be:
- SB: the byte replicated 4x.
- SH: the halfword replicated 2x.
- SW: rs2data_em.
REQ-025 Load data SHALL be:
- Byte: dmem_rdata[8*ea[1:0]+:8].
- Half: dmem_rdata[16*ea[1]+:16].
- LB/LH sign-extended to XLEN, LBU/LHU zero-extended, LW unmodified.
REQ-026 When phase_memory=0 in IDLE, the latch and FSM SHALL hold.
REQ-027 In BUSY, changes on the _em inputs SHALL NOT alter bus outputs (the inputs are held upstream by the stall).

Reset
REQ-028 rst=1 SHALL asynchronously force:
- FSM to IDLE.
- dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata to 0.
- All _mw outputs to 0.
- mem_err to 0.
- stall_memory to 0.
REQ-029 rst asserted in BUSY SHALL abandon the access with dmem_req dropping without a clock; an ack in the first cycle after release SHALL be ignored.

Verification
REQ-030 ALU op, alu_out_em=0x1234, phase_memory=1 -> rddata_mw=0x1234 next edge, stall_memory never 1.
REQ-031 LB ea=0x103, dmem_rdata=0x80FFFFFF, ack on first req cycle:
- dmem_addr=0x100, be=0000 with we=0.
- rddata_mw=0xFFFFFF80 after 2 cycles.
- LBU gives 0x00000080.
REQ-032 SH ea=0x202, rs2data_em=0xABCD1234:
- be=1100, wdata=0x12341234, we=1.
- ack delayed 3 cycles -> stall_memory=1 for 4 cycles, req stable throughout.
REQ-033 LW ea=0x101 -> no dmem_req, mem_err pulses 1 cycle, rddata_mw=0; f3=011 load behaves the same.
REQ-034 rst pulsed while BUSY, then ack held -> dmem_req=0 immediately, FSM IDLE, outputs 0, no latch update.
REQ-035 Spurious dmem_ack in IDLE -> no latch change, no stall.
